image_compressor: RTL and testbench

- Consumer end of the compress request/start handshake.
- On compress_start, takes one raster scan of the 224x224 1-bit canvas and downsamples it by 8x8 box-sum to a 28x28 8-bit grayscale image.
- Writes the result into the compressed-image RAM that feeds the recognition datapath.
- Asserts busy for the whole scan, pulses done after the last write, and aborts with err on an out-of-order scan.

---
 rtl/compress_pkg.sv | 23 ++
 rtl/block_accum_bank.sv | 29 ++
 rtl/image_compressor.sv | 123 ++++++++++++
 tb/tb_image_compressor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared parameters, FSM state type and pixel scaling for the canvas compressor.
package compress_pkg;

  localparam int unsigned SRC_DIM = 224;
  localparam int unsigned BLK     = 8;
  localparam int unsigned DST_DIM = 28;
  localparam int unsigned CMP_AW  = 10;
  localparam int unsigned THRESH  = 128;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned PIX_W   = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} cmp_state_t;

  // Ink count (0..64) times four, saturated to 8 bits so a full block reads 255.
  function automatic logic [PIX_W-1:0] scale_sat(input logic [CNT_W-1:0] count);
    logic [CNT_W+1:0] v;
    v = {count, 2'b00};
    return (v > (CNT_W+2)'(255)) ? 8'hFF : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/block_accum_bank.sv
// One ink counter per output column; a capture reads the sum including the current pixel and clears.
module block_accum_bank
  import compress_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             add_bit,
  input  logic             cap_en,
  input  logic             clr_all,
  output logic [CNT_W-1:0] sum_c
);

  logic [CNT_W-1:0] acc [DST_DIM];

  assign sum_c = acc[idx] + CNT_W'(add_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DST_DIM; i++) acc[i] <= '0;
    end else if (clr_all) begin
      for (int unsigned i = 0; i < DST_DIM; i++) acc[i] <= '0;
    end else if (add_en) begin
      acc[idx] <= cap_en ? '0 : sum_c;
    end
  end

endmodule

// File: rtl/image_compressor.sv
// Raster-scan 8x8 box-sum downsampler from the 224x224 1-bit canvas to a 28x28 8-bit RAM image.
// Define COMPRESS_BINARIZE_EN to write 8'hFF/8'h00 against THRESH instead of grayscale.
module image_compressor
  import compress_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               compress_start,
  input  logic               pix_vld,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_data,
  output logic               cmp_we,
  output logic [CMP_AW-1:0]  cmp_addr,
  output logic [PIX_W-1:0]   cmp_wdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if ((DST_DIM != SRC_DIM / BLK) || (SRC_DIM % BLK != 0)) begin : g_dim_check
    $error("image_compressor: DST_DIM must equal SRC_DIM/BLK with SRC_DIM a multiple of BLK");
  end

  localparam logic [COORD_W-1:0] LAST = COORD_W'(SRC_DIM - 1);

  cmp_state_t         state, state_d;
  logic [COORD_W-1:0] exp_x, exp_y;
  logic               accept_c, bad_c, emit_c;
  logic [IDX_W-1:0]   bx_c, by_c;
  logic [CNT_W-1:0]   sum_c;
  logic [PIX_W-1:0]   scaled_c, wdata_c;
  logic [CMP_AW-1:0]  addr_c;

  assign bx_c   = pix_x[COORD_W-1:3];
  assign by_c   = pix_y[COORD_W-1:3];
  assign emit_c = accept_c && (pix_x[2:0] == 3'b111) && (pix_y[2:0] == 3'b111);
  assign addr_c = CMP_AW'(by_c) * CMP_AW'(DST_DIM) + CMP_AW'(bx_c);

  block_accum_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .add_en  (accept_c),
    .idx     (bx_c),
    .add_bit (pix_data),
    .cap_en  (emit_c),
    .clr_all (bad_c),
    .sum_c   (sum_c)
  );

  always_comb begin
    scaled_c = scale_sat(sum_c);
`ifdef COMPRESS_BINARIZE_EN
    wdata_c  = (scaled_c >= PIX_W'(THRESH)) ? 8'hFF : 8'h00;
`else
    wdata_c  = scaled_c;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Start detection and scan-order checking; a wrong coordinate aborts the scan.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    bad_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (compress_start && pix_vld && (pix_x == '0) && (pix_y == '0)) begin
          accept_c = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (pix_vld) begin
          if ((pix_x == exp_x) && (pix_y == exp_y)) begin
            accept_c = 1'b1;
            if ((pix_x == LAST) && (pix_y == LAST)) state_d = FINISH;
          end else begin
            bad_c   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Expected raster position, plus the one-cycle write stage and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_x     <= '0;
      exp_y     <= '0;
      cmp_we    <= 1'b0;
      cmp_addr  <= '0;
      cmp_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state_d == IDLE) begin
        exp_x <= '0;
        exp_y <= '0;
      end else if (accept_c) begin
        exp_x <= (pix_x == LAST) ? '0 : pix_x + COORD_W'(1);
        exp_y <= (pix_x == LAST) ? pix_y + COORD_W'(1) : pix_y;
      end
      cmp_we <= emit_c;
      if (emit_c) begin
        cmp_addr  <= addr_c;
        cmp_wdata <= wdata_c;
      end
      busy <= (state_d != IDLE);
      done <= (state_d == FINISH);
      err  <= bad_c;
    end
  end

endmodule

// File: tb/tb_image_compressor.sv
// Directed bench for image_compressor: reset, scan abort, mid-scan reset and one full patterned scan.
module tb_image_compressor;

  logic       clk = 1'b0;
  logic       rst;
  logic       compress_start, pix_vld, pix_data;
  logic [7:0] pix_x, pix_y;
  logic       cmp_we, busy, done, err;
  logic [9:0] cmp_addr;
  logic [7:0] cmp_wdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;

  image_compressor dut (
    .clk            (clk),
    .rst            (rst),
    .compress_start (compress_start),
    .pix_vld        (pix_vld),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_data       (pix_data),
    .cmp_we         (cmp_we),
    .cmp_addr       (cmp_addr),
    .cmp_wdata      (cmp_wdata),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmp_we === 1'b1) wr_cnt++;
    if (err === 1'b1)    err_cnt++;
    if (done === 1'b1)   done_cnt++;
  end

  // Canvas: bottom 8 block rows solid, block (by=1,bx=2) half ink, block (3,5) one pixel.
  function automatic logic ink(input int x, input int y);
    if (y / 8 >= 20) return 1'b1;
    if (y / 8 == 1 && x / 8 == 2) return (x % 2 == 0);
    if (y / 8 == 3 && x / 8 == 5) return (x % 8 == 0 && y % 8 == 0);
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_val(input int bx, input int by);
    int cnt, v;
    cnt = 0;
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 8; xx++)
        cnt += int'(ink(bx * 8 + xx, by * 8 + yy));
    v = cnt * 4;
    if (v > 255) v = 255;
`ifdef COMPRESS_BINARIZE_EN
    v = (v >= 128) ? 255 : 0;
`endif
    return 8'(v);
  endfunction

  task automatic drive_beat(input int x, input int y, input logic d, input logic st);
    pix_vld = 1'b1;
    pix_x = 8'(x);
    pix_y = 8'(y);
    pix_data = d;
    compress_start = st;
    @(negedge clk);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      pix_vld = 1'b0;
      compress_start = 1'b0;
      pix_data = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_idle(3);
    checks++; if (cmp_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", cmp_we); end
    checks++; if (cmp_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", cmp_addr); end
    checks++; if (cmp_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", cmp_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    drive_idle(2);
  endtask

  task automatic test_scan_order_error;
    int w0;
    w0 = wr_cnt;
    for (int x = 0; x <= 4; x++) drive_beat(x, 0, 1'b1, x == 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL order_busy_before: got %b expected 1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL order_err_before: got %b expected 0", err); end
    drive_beat(6, 0, 1'b1, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL order_err_pulse: got %b expected 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_busy_drop: got %b expected 0", busy); end
    checks++; if (cmp_we !== 1'b0) begin errors++; $display("FAIL order_no_write: got %b expected 0", cmp_we); end
    for (int x = 7; x < 40; x++) drive_beat(x % 224, 0, 1'b1, 1'b0);
    drive_beat(7, 7, 1'b1, 1'b0);
    drive_idle(3);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL order_err_single: got %b expected 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL order_stays_idle: got %b expected 0", busy); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL order_writes: got %0d expected 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_scan;
    int w0, e0;
    e0 = err_cnt;
    for (int y = 0; y <= 50; y++)
      for (int x = 0; x < 224; x++)
        if (y < 50 || x <= 100) drive_beat(x, y, ink(x, y), x == 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    checks++; if (cmp_addr !== 10'd167) begin errors++; $display("FAIL midrst_last_addr: got %0d expected 167", cmp_addr); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_restart_err: got %0d expected 0", err_cnt - e0); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({cmp_we, cmp_addr, cmp_wdata, busy, done, err} !== 22'd0) begin
      errors++; $display("FAIL midrst_async_clear: got we=%b addr=%0d wdata=%0h busy=%b done=%b err=%b expected all 0",
                         cmp_we, cmp_addr, cmp_wdata, busy, done, err);
    end
    drive_idle(2);
    rst = 1'b0;
    w0 = wr_cnt;
    for (int x = 101; x < 224; x++) drive_beat(x, 50, 1'b1, 1'b0);
    drive_idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", busy); end
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL midrst_no_writes: got %0d expected 0", wr_cnt - w0); end
  endtask

  task automatic test_full_scan;
    int w0, e0, d0, busy_low;
    logic [9:0] ea;
    logic [7:0] ed;
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt; busy_low = 0;
    for (int y = 0; y < 224; y++) begin
      for (int x = 0; x < 224; x++) begin
        if (y < 16) begin
          while ($urandom_range(0, 99) < 40) begin
            pix_vld = 1'b0;
            pix_x = 8'd0;
            pix_y = 8'd0;
            compress_start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (!(x == 0 && y == 0) && busy !== 1'b1) busy_low++;
          end
        end
        drive_beat(x, y, ink(x, y), x == 0);
        if (busy !== 1'b1) busy_low++;
        if (x % 8 == 7 && y % 8 == 7) begin
          ea = 10'((y / 8) * 28 + x / 8);
          ed = exp_val(x / 8, y / 8);
          checks++; if (cmp_we !== 1'b1) begin errors++; $display("FAIL scan_we @%0d: got %b expected 1", ea, cmp_we); end
          checks++; if (cmp_addr !== ea) begin errors++; $display("FAIL scan_addr: got %0d expected %0d", cmp_addr, ea); end
          checks++; if (cmp_wdata !== ed) begin errors++; $display("FAIL scan_wdata @%0d: got %0h expected %0h", ea, cmp_wdata, ed); end
          if (x == 223 && y == 223) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL scan_done_with_last: got %b expected 1", done); end
          end
        end
      end
    end
    drive_idle(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL scan_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy_end: got %b expected 0", busy); end
    drive_idle(3);
    checks++; if (wr_cnt - w0 !== 784) begin errors++; $display("FAIL scan_write_count: got %0d expected 784", wr_cnt - w0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL scan_err_count: got %0d expected 0", err_cnt - e0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL scan_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL scan_busy_held: got %0d low cycles expected 0", busy_low); end
  endtask

  initial begin
    rst = 1'b1;
    compress_start = 1'b0;
    pix_vld = 1'b0;
    pix_data = 1'b0;
    pix_x = 8'd0;
    pix_y = 8'd0;
    @(negedge clk);
    test_reset;
    test_scan_order_error;
    test_reset_mid_scan;
    test_full_scan;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
